// File: rtl/fifo_pkg.sv
// Shared FIFO status types, used by the FIFO and by the UART status register decode.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic unf;
  } fifo_status_t;

endpackage

// File: rtl/fifo_buffer_lvl_chk.sv
// Invariant checker for fifo_buffer_lvl: occupancy bound and full/empty exclusivity.
module fifo_buffer_lvl_chk #(
  parameter int SIZE_FIFO  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE_FIFO)
) (
  input logic                i_clk,
  input logic                i_reset_n,
  input logic [ADDR_WIDTH:0] i_level,
  input logic                i_full,
  input logic                i_empty
);

  localparam logic [ADDR_WIDTH:0] FULL_C = (ADDR_WIDTH + 1)'(SIZE_FIFO);

  a_level_max: assert property (@(posedge i_clk) disable iff (!i_reset_n) i_level <= FULL_C);
  a_full_empty: assert property (@(posedge i_clk) disable iff (!i_reset_n) !(i_full && i_empty));

endmodule

// File: rtl/fifo_mem_2p.sv
// Two-port storage array for the FIFO: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE_FIFO)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_idx,
  input  logic [DATA_SIZE-1:0]  i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx,
  output logic [DATA_SIZE-1:0]  o_rd_data
);

  logic [DATA_SIZE-1:0] mem_r [SIZE_FIFO];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_r[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_r[i_rd_idx];

endmodule

// File: rtl/fifo_buffer_lvl.sv
// Show-ahead synchronous FIFO with occupancy level, programmable almost flags,
// synchronous flush and sticky overflow/underflow flags for the UART status register.
module fifo_buffer_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE_FIFO),
  parameter int AFULL_LVL  = SIZE_FIFO - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_write_en,
  input  logic [DATA_SIZE-1:0] i_data_in,
  input  logic                 i_read_en,
  input  logic                 i_clr_err,
  output logic [DATA_SIZE-1:0] o_data_out,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [ADDR_WIDTH:0]  o_level,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int                  LW       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] FULL_C   = LW'(SIZE_FIFO);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = LW'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = LW'(AEMPTY_LVL);
  localparam logic [ADDR_WIDTH:0] ONE_C    = LW'(1);
  localparam fifo_status_t        RST_C    = '{full: 1'b0, empty: 1'b1,
                                               afull: (AFULL_LVL == 32'sd0),
                                               aempty: 1'b1, ovf: 1'b0, unf: 1'b0};

  logic [ADDR_WIDTH:0] wr_ptr_r, rd_ptr_r, level_r, level_nxt_s;
  fifo_status_t        status_r, status_nxt_s;
  logic                rd_acc_s, wr_acc_s, mem_wr_s;

  assign rd_acc_s = i_read_en & ~status_r.empty;
  // A full FIFO still takes a write when the same edge frees the head slot.
  assign wr_acc_s = i_write_en & (~status_r.full | rd_acc_s);
  assign mem_wr_s = wr_acc_s & ~i_flush;

  fifo_mem_2p #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_FIFO (SIZE_FIFO),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .i_clk    (i_clk),
    .i_wr_en  (mem_wr_s),
    .i_wr_idx (wr_ptr_r[ADDR_WIDTH-1:0]),
    .i_wr_data(i_data_in),
    .i_rd_idx (rd_ptr_r[ADDR_WIDTH-1:0]),
    .o_rd_data(o_data_out)
  );

  // Next occupancy and flag state; flush discards this cycle's requests.
  always_comb begin
    level_nxt_s  = level_r;
    status_nxt_s = status_r;
    if (i_flush) begin
      level_nxt_s      = '0;
      status_nxt_s.ovf = status_r.ovf & ~i_clr_err;
      status_nxt_s.unf = status_r.unf & ~i_clr_err;
    end else begin
      if (wr_acc_s && !rd_acc_s) begin
        level_nxt_s = level_r + ONE_C;
      end else if (rd_acc_s && !wr_acc_s) begin
        level_nxt_s = level_r - ONE_C;
      end else begin
        level_nxt_s = level_r;
      end
      status_nxt_s.ovf = (i_write_en & ~wr_acc_s) | (status_r.ovf & ~i_clr_err);
      status_nxt_s.unf = (i_read_en & status_r.empty) | (status_r.unf & ~i_clr_err);
    end
    status_nxt_s.full   = (level_nxt_s == FULL_C);
    status_nxt_s.empty  = (level_nxt_s == '0);
    status_nxt_s.afull  = (level_nxt_s >= AFULL_C);
    status_nxt_s.aempty = (level_nxt_s <= AEMPTY_C);
  end

  // Pointer, level and flag registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      status_r <= RST_C;
    end else begin
      level_r  <= level_nxt_s;
      status_r <= status_nxt_s;
      if (i_flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_acc_s) wr_ptr_r <= wr_ptr_r + ONE_C;
        if (rd_acc_s) rd_ptr_r <= rd_ptr_r + ONE_C;
      end
    end
  end

  assign o_level        = level_r;
  assign o_full         = status_r.full;
  assign o_empty        = status_r.empty;
  assign o_almost_full  = status_r.afull;
  assign o_almost_empty = status_r.aempty;
  assign o_overflow     = status_r.ovf;
  assign o_underflow    = status_r.unf;

endmodule
